// File: rtl/fs_dither_kernel.sv
// fs_dither_kernel: Floyd-Steinberg error-diffusion engine sitting between the
// three-row line buffer bank and the frame store. It quantises the row-y pixel
// to one bit and writes error-adjusted row-(y+1) pixels back to the buffer.
// Optional build macro FS_DITHER_THRESH_PORT_EN adds thresh_in[7:0], which is
// sampled at column 0 and held for the row (THRESH becomes its reset value).
//
// state | meaning
// IDLE  | waiting for column 0 of a row; other columns are ignored
// RUN   | accepting columns 1..FRAME_WIDTH-1
// FLUSH | one-cycle tail that finalises and writes back the last column
//
// A row needs at least one idle cycle after its last column (the FLUSH slot)
// before the next row's column 0 is accepted.
module fs_dither_kernel #(
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 240,
  parameter int THRESH       = 128
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  cur_pixel,
  input  logic [7:0]  below_pixel,
  input  logic [10:0] in_hcount,
  input  logic [9:0]  in_vcount,
  input  logic        in_valid,
  input  logic        freeze,
`ifdef FS_DITHER_THRESH_PORT_EN
  input  logic [7:0]  thresh_in,
`endif
  output logic        dith_pixel,
  output logic [10:0] dith_hcount,
  output logic [9:0]  dith_vcount,
  output logic        dith_valid,
  output logic [7:0]  wb_data,
  output logic [10:0] wb_hcount,
  output logic        wb_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [10:0] LAST_COL = 11'(FRAME_WIDTH - 1);
  localparam logic [9:0]  LAST_ROW = 10'(FRAME_HEIGHT - 1);
  localparam logic [7:0]  THRESH8  = 8'(THRESH);

  function automatic logic [7:0] clamp8(input logic signed [10:0] s);
    if (s < 0)             clamp8 = 8'd0;
    else if (s > 11'sd255) clamp8 = 8'd255;
    else                   clamp8 = s[7:0];
  endfunction

  state_t state_q, state_d;
  logic signed [9:0] e_right_q, e_right_d;
  // acc1 holds the pending error for the column just behind the input (x-1),
  // acc2 the 1/16 share already queued for column x; the finalised column
  // value drops straight into the write-back stage.
  logic signed [9:0] acc1_q, acc1_d, acc2_q, acc2_d;
  logic [7:0]  below_prev_q, below_prev_d;
  logic        last_row_q, last_row_d;
  logic        p1_dith_q, p1_dith_d, p1_dvalid_q, p1_dvalid_d;
  logic [10:0] p1_hcount_q, p1_hcount_d, p1_wb_hcount_q, p1_wb_hcount_d;
  logic [9:0]  p1_vcount_q, p1_vcount_d;
  logic [7:0]  p1_wb_data_q, p1_wb_data_d;
  logic        p1_wb_valid_q, p1_wb_valid_d;
  logic        dith_q, dith_d, dvalid_q, dvalid_d, wb_valid_q, wb_valid_d;
  logic [10:0] dhcount_q, dhcount_d, wb_hcount_q, wb_hcount_d;
  logic [9:0]  dvcount_q, dvcount_d;
  logic [7:0]  wb_data_q, wb_data_d;

  logic              accept, flush, first, last;
  logic [7:0]        thr_cur, v;
  logic signed [9:0] e_eff, err, e7, e5, e3, e1, prev_final, wb_acc;
  logic signed [10:0] sum, wb_sum;
  logic signed [13:0] err_x;
  logic              q_out;

`ifdef FS_DITHER_THRESH_PORT_EN
  logic [7:0] thresh_q, thresh_d;
`endif

  // FSM state register plus all datapath and pipeline flops
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;       e_right_q <= '0;     acc1_q <= '0;      acc2_q <= '0;
      below_prev_q <= '0;    last_row_q <= 1'b0;
      p1_dith_q <= 1'b0;     p1_dvalid_q <= 1'b0; p1_hcount_q <= '0; p1_vcount_q <= '0;
      p1_wb_data_q <= '0;    p1_wb_hcount_q <= '0; p1_wb_valid_q <= 1'b0;
      dith_q <= 1'b0;        dvalid_q <= 1'b0;    dhcount_q <= '0;   dvcount_q <= '0;
      wb_data_q <= '0;       wb_hcount_q <= '0;   wb_valid_q <= 1'b0;
`ifdef FS_DITHER_THRESH_PORT_EN
      thresh_q <= THRESH8;
`endif
    end else begin
      state_q <= state_d;    e_right_q <= e_right_d; acc1_q <= acc1_d; acc2_q <= acc2_d;
      below_prev_q <= below_prev_d; last_row_q <= last_row_d;
      p1_dith_q <= p1_dith_d; p1_dvalid_q <= p1_dvalid_d;
      p1_hcount_q <= p1_hcount_d; p1_vcount_q <= p1_vcount_d;
      p1_wb_data_q <= p1_wb_data_d; p1_wb_hcount_q <= p1_wb_hcount_d;
      p1_wb_valid_q <= p1_wb_valid_d;
      dith_q <= dith_d;      dvalid_q <= dvalid_d; dhcount_q <= dhcount_d; dvcount_q <= dvcount_d;
      wb_data_q <= wb_data_d; wb_hcount_q <= wb_hcount_d; wb_valid_q <= wb_valid_d;
`ifdef FS_DITHER_THRESH_PORT_EN
      thresh_q <= thresh_d;
`endif
    end
  end

  // FSM next-state: freeze holds the state, including the FLUSH slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = last ? FLUSH : RUN;
      RUN:     if (accept && last) state_d = FLUSH;
      FLUSH:   if (!freeze) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: which input beat is taken this cycle and when the tail runs
  always_comb begin
    first  = (in_hcount == 11'd0);
    last   = (in_hcount == LAST_COL);
    accept = !freeze && in_valid && ((state_q == IDLE && first) || state_q == RUN);
    flush  = !freeze && (state_q == FLUSH);
  end

  // Quantiser and error split; products are 14-bit signed, floored by >>> 4
  always_comb begin
`ifdef FS_DITHER_THRESH_PORT_EN
    thr_cur = first ? thresh_in : thresh_q;
`else
    thr_cur = THRESH8;
`endif
    e_eff = first ? 10'sd0 : e_right_q;
    sum   = $signed({3'b000, cur_pixel}) + $signed({e_eff[9], e_eff});
    v     = clamp8(sum);
    q_out = (v >= thr_cur);
    err   = $signed({2'b00, v}) - (q_out ? 10'sd255 : 10'sd0);
    err_x = {{4{err[9]}}, err};
    e7    = 10'(((err_x <<< 3) - err_x) >>> 4);
    e5    = 10'(((err_x <<< 2) + err_x) >>> 4);
    e3    = 10'(((err_x <<< 1) + err_x) >>> 4);
    e1    = 10'(err_x >>> 4);
    prev_final = acc1_q + e3;
    wb_acc     = flush ? acc1_q : prev_final;
    wb_sum     = $signed({3'b000, below_prev_q}) + $signed({wb_acc[9], wb_acc});
  end

  // Error window, below-row history and the two pipeline stages
  always_comb begin
    e_right_d = e_right_q;  acc1_d = acc1_q;  acc2_d = acc2_q;
    below_prev_d = below_prev_q;  last_row_d = last_row_q;
`ifdef FS_DITHER_THRESH_PORT_EN
    thresh_d = (accept && first) ? thresh_in : thresh_q;
`endif
    if (accept) begin
      e_right_d    = last ? 10'sd0 : e7;
      acc1_d       = (first ? 10'sd0 : acc2_q) + e5;
      acc2_d       = last ? 10'sd0 : e1;
      below_prev_d = below_pixel;
      last_row_d   = (in_vcount == LAST_ROW);
    end else if (flush) begin
      e_right_d = '0;  acc1_d = '0;  acc2_d = '0;
    end
    p1_dith_d = p1_dith_q;  p1_dvalid_d = p1_dvalid_q;
    p1_hcount_d = p1_hcount_q;  p1_vcount_d = p1_vcount_q;
    p1_wb_data_d = p1_wb_data_q;  p1_wb_hcount_d = p1_wb_hcount_q;
    p1_wb_valid_d = p1_wb_valid_q;
    dith_d = dith_q;  dvalid_d = dvalid_q;  dhcount_d = dhcount_q;  dvcount_d = dvcount_q;
    wb_data_d = wb_data_q;  wb_hcount_d = wb_hcount_q;  wb_valid_d = wb_valid_q;
    if (!freeze) begin
      p1_dith_d      = q_out;
      p1_dvalid_d    = accept;
      p1_hcount_d    = in_hcount;
      p1_vcount_d    = in_vcount;
      p1_wb_data_d   = clamp8(wb_sum);
      p1_wb_hcount_d = flush ? LAST_COL : 11'(in_hcount - 11'd1);
      p1_wb_valid_d  = (accept && !first && in_vcount != LAST_ROW) || (flush && !last_row_q);
      dith_d = p1_dith_q;  dvalid_d = p1_dvalid_q;
      dhcount_d = p1_hcount_q;  dvcount_d = p1_vcount_q;
      wb_data_d = p1_wb_data_q;  wb_hcount_d = p1_wb_hcount_q;  wb_valid_d = p1_wb_valid_q;
    end
  end

  // Strobes are suppressed while frozen; the held beat shows once on release
  always_comb begin
    dith_pixel  = dith_q;
    dith_hcount = dhcount_q;
    dith_vcount = dvcount_q;
    dith_valid  = dvalid_q && !freeze;
    wb_data     = wb_data_q;
    wb_hcount   = wb_hcount_q;
    wb_valid    = wb_valid_q && !freeze;
  end

endmodule
